man_jump: RTL
=============

# man_jump

Jump-trajectory generator that consumes the squeeze count produced by the man-squeeze stage. When the game state moves from PRESS to JUMP it latches the squeeze value, converts it to a horizontal jump distance, and then steps a parabolic flight over a fixed number of frame ticks. Its per-frame position offsets feed the sprite renderer and landing check, and its done pulse feeds the game state machine.

## Interface
- SQ_W, 8: width of the squeeze count input
- GAIN, 2: pixels of horizontal distance per squeeze unit
- LOG2_STEPS, 5: log2 of the flight length in frame ticks (N = 32)
- H_MAX, 48: apex height in pixels
- DX_W, 10: width of horizontal offset output
- DY_W, 8: width of vertical offset output
- ST_PRESS, 3: state code for "pressing / squeezing"
- ST_JUMP, 4: state code for "jumping"
- clk_machine  in  1  single clock, 25 MHz
- rst_machine  in  1  asynchronous reset, active-high
- state  in  3  current game state code
- i_squeeze_man  in  SQ_W  squeeze count from the squeeze stage
- i_frame_tick  in  1  one-cycle pulse per video frame
- o_jump_dx  out  DX_W  horizontal offset from the take-off point
- o_jump_dy  out  DY_W  vertical offset above ground, positive up
- o_jump_busy  out  1  high while in flight
- o_jump_done  out  1  one-cycle pulse on landing

## Operation
- Internal registers: prev_state (3 b), distance D (DX_W), step t (LOG2_STEPS+1 b), FSM {IDLE, FLY, LAND}.
- Launch condition: prev_state == ST_PRESS and state == ST_JUMP, evaluated every cycle.
- On launch from any FSM state: D <= min(i_squeeze_man*GAIN, 2^DX_W-1), t <= 0, dx = dy = 0, go to FLY.
- FLY, on i_frame_tick: t <= t+1. Outputs recompute from the new t:
  - dx = (D*t) >> LOG2_STEPS
  - dy = (4*H_MAX*t*(N-t)) >> (2*LOG2_STEPS), saturated to 2^DY_W-1
- Intermediate products are full-width, with no truncation before the shift.
- FLY to LAND: when the new t == N, set dx = D, dy = 0, pulse done, drop busy.
- LAND: hold dx = D and dy = 0. When state != ST_JUMP, go to IDLE and clear dx and dy to 0.
- Abort: in FLY, if state != ST_JUMP and there is no launch, go to IDLE. dx and dy clear to 0, busy drops, no done pulse.
- IDLE: dx = dy = 0, busy = 0, ticks ignored.
- A squeeze of 0 is legal. It gives D = 0 and a full vertical arc with dx = 0 throughout.

## Timing
- Reset values:
  - FSM = IDLE, prev_state = 0, D = 0, t = 0.
  - o_jump_dx = 0, o_jump_dy = 0, o_jump_busy = 0, o_jump_done = 0.
- All outputs are registered.
- Launch detected in cycle c: o_jump_busy = 1 from cycle c+1, and i_squeeze_man is sampled in cycle c.
- Tick sampled in cycle c: dx, dy and t for step t+1 are visible in cycle c+1.
- o_jump_done is high for exactly the cycle in which dx first equals D. It coincides with busy falling.
- Launch and tick in the same cycle: launch wins and the tick is ignored (t stays 0).
- Ticks arriving faster than 1 per 2 cycles are still each counted.
- Reset asserted mid-flight: all outputs clear immediately (asynchronous) and no done pulse is generated.
- A flight takes exactly N ticks.

## Test plan
- Squeeze 20, PRESS→JUMP, then 32 ticks. Required responses:
  - after tick 8: dx = 10, dy = 36
  - after tick 16: dx = 20, dy = 48
  - after tick 32: dx = 40, dy = 0, with a 1-cycle done pulse and busy falling.
- Squeeze 0, full flight: dx = 0 throughout, dy peaks at 48 at tick 16, done fires after tick 32.
- Abort: state goes JUMP→0 after tick 10. Next cycle: dx = 0, dy = 0, busy = 0, no done pulse; later ticks cause no change.
- Reset at tick 12 of a flight: all outputs are 0 without waiting for a clock edge. After release, ticks are ignored until the next PRESS→JUMP.
- Launch coincident with i_frame_tick: t stays 0, dx = dy = 0. The next tick gives step 1 (squeeze 20 gives dx = 1, dy = 5).
- Direct 0→JUMP transition with no PRESS state: no launch and busy stays 0. GAIN = 8 with squeeze 255: D clamps to 1023.

Source files
------------

// File: rtl/man_jump.sv
// Jump-trajectory generator: latches squeeze on PRESS->JUMP, steps a parabolic arc over N frame ticks.
// Registered outputs; each sampled tick appears one cycle later, and done pulses as busy falls.
module man_jump #(
    parameter int         SQ_W       = 8,
    parameter int         GAIN       = 2,
    parameter int         LOG2_STEPS = 5,
    parameter int         H_MAX      = 48,
    parameter int         DX_W       = 10,
    parameter int         DY_W       = 8,
    parameter logic [2:0] ST_PRESS   = 3'd3,
    parameter logic [2:0] ST_JUMP    = 3'd4
) (
    input  logic            clk_machine,
    input  logic            rst_machine,
    input  logic [2:0]      state,
    input  logic [SQ_W-1:0] i_squeeze_man,
    input  logic            i_frame_tick,
    output logic [DX_W-1:0] o_jump_dx,
    output logic [DY_W-1:0] o_jump_dy,
    output logic            o_jump_busy,
    output logic            o_jump_done
);
    localparam int TW = LOG2_STEPS + 1;
    localparam int N  = 1 << LOG2_STEPS;
    localparam int PW = DX_W + TW;
    localparam logic [63:0] DX_MAX = (64'd1 << DX_W) - 64'd1;
    localparam logic [63:0] DY_MAX = (64'd1 << DY_W) - 64'd1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_LAND = 2'd2;

    logic [1:0]      fsm_q, fsm_d;
    logic [2:0]      prev_state_q, prev_state_d;
    logic [DX_W-1:0] d_q, d_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            launch;
    logic [TW-1:0]   t_nxt;
    logic [63:0]     d_raw;
    logic [DX_W-1:0] d_clamp;
    logic [PW-1:0]   dx_prod;
    logic [DX_W-1:0] dx_val;
    logic [63:0]     dy_prod;
    logic [63:0]     dy_sh;
    logic [DY_W-1:0] dy_val;

    // Products are kept full width so the shift sees every bit.
    always_comb begin
        launch  = (prev_state_q == ST_PRESS) && (state == ST_JUMP);
        t_nxt   = t_q + TW'(1);
        d_raw   = 64'(i_squeeze_man) * 64'(GAIN);
        d_clamp = (d_raw > DX_MAX) ? DX_W'(DX_MAX) : DX_W'(d_raw);
        dx_prod = PW'(d_q) * PW'(t_nxt);
        dx_val  = DX_W'(dx_prod >> LOG2_STEPS);
        dy_prod = 64'(4 * H_MAX) * 64'(t_nxt) * (64'(N) - 64'(t_nxt));
        dy_sh   = dy_prod >> (2 * LOG2_STEPS);
        dy_val  = (dy_sh > DY_MAX) ? DY_W'(DY_MAX) : DY_W'(dy_sh);
    end

    always_comb begin
        fsm_d        = fsm_q;
        prev_state_d = state;
        d_d          = d_q;
        t_d          = t_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        if (launch) begin
            fsm_d  = S_FLY;
            d_d    = d_clamp;
            t_d    = '0;
            dx_d   = '0;
            dy_d   = '0;
            busy_d = 1'b1;
        end else begin
            case (fsm_q)
                S_FLY: begin
                    if (state != ST_JUMP) begin
                        fsm_d  = S_IDLE;
                        dx_d   = '0;
                        dy_d   = '0;
                        busy_d = 1'b0;
                    end else if (i_frame_tick) begin
                        t_d = t_nxt;
                        if (t_nxt == TW'(N)) begin
                            fsm_d  = S_LAND;
                            dx_d   = d_q;
                            dy_d   = '0;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            dx_d = dx_val;
                            dy_d = dy_val;
                        end
                    end
                end
                S_LAND: begin
                    if (state != ST_JUMP) begin
                        fsm_d = S_IDLE;
                        dx_d  = '0;
                        dy_d  = '0;
                    end
                end
                default: begin
                    fsm_d  = S_IDLE;
                    dx_d   = '0;
                    dy_d   = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            fsm_q        <= S_IDLE;
            prev_state_q <= '0;
            d_q          <= '0;
            t_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= prev_state_d;
            d_q          <= d_d;
            t_q          <= t_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_jump_dx   = dx_q;
    assign o_jump_dy   = dy_q;
    assign o_jump_busy = busy_q;
    assign o_jump_done = done_q;
endmodule
